r_response_memory: RTL and testbench

- Holds out-of-order read-response beats that the ordering unit cannot forward yet, then returns them beat by beat when that unit asks for a given unique ID (uid).
- Sits beside the ordering unit on its store and release channels.
- Storage is one shared pool of DEPTH beat slots. Each uid owns a singly linked FIFO of slots, so per-uid beat order is kept.
- The free list is a bitmap.

---
 rtl/r_response_memory.sv | 137 +++++++++++++
 tb/tb_r_response_memory.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/r_response_memory.sv
// r_response_memory: shared pool of read-response beats, organised as one
// singly linked FIFO per uid. Beats are stored when the ordering unit cannot
// forward them yet and are released, oldest first, when it asks for a uid.
module r_response_memory #(
    parameter int ID_WIDTH   = 32,
    parameter int NUM_ROWS   = 16,
    parameter int NUM_COLS   = 16,
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     store_valid,
    output logic                     store_ready,
    input  logic [ID_WIDTH-1:0]      store_uid,
    input  logic [DATA_WIDTH-1:0]    store_data,
    input  logic [RESP_WIDTH-1:0]    store_resp,
    input  logic                     store_last,
    input  logic [ID_WIDTH-1:0]      release_uid,
    input  logic                     release_ready,
    output logic                     release_valid,
    output logic [DATA_WIDTH-1:0]    release_data,
    output logic [RESP_WIDTH-1:0]    release_resp,
    output logic                     release_last,
    output logic [$clog2(DEPTH):0]   free_count
);

    localparam int ROW_W    = $clog2(NUM_ROWS);
    localparam int COL_W    = $clog2(NUM_COLS);
    localparam int UID_W    = ROW_W + COL_W;
    localparam int NUM_UIDS = 1 << UID_W;
    localparam int PTR_W    = $clog2(DEPTH);

    // Beat storage and the per-slot link to the next beat of the same uid
    logic [DATA_WIDTH-1:0] slot_data [DEPTH];
    logic [RESP_WIDTH-1:0] slot_resp [DEPTH];
    logic                  slot_last [DEPTH];
    logic [PTR_W-1:0]      slot_next [DEPTH];

    // Free-slot bitmap and per-uid list descriptors
    logic [DEPTH-1:0]      free_map;
    logic [PTR_W-1:0]      head_ptr [NUM_UIDS];
    logic [PTR_W-1:0]      tail_ptr [NUM_UIDS];
    logic [NUM_UIDS-1:0]   nonempty;

    logic [UID_W-1:0]      store_idx;
    logic [UID_W-1:0]      rel_idx;
    logic [PTR_W-1:0]      rel_head;
    logic [PTR_W-1:0]      alloc_idx;
    logic                  store_fire;
    logic                  pop_fire;
    logic                  pop_single;
    logic                  store_fresh;

    // Only the low row/column bits of a uid select a list; the rest are ignored
    generate
        if (ID_WIDTH > UID_W) begin : g_unused_uid
            logic unused_uid_bits;
            assign unused_uid_bits = ^{store_uid[ID_WIDTH-1:UID_W],
                                       release_uid[ID_WIDTH-1:UID_W]};
        end
    endgenerate

    assign store_idx = store_uid[UID_W-1:0];
    assign rel_idx   = release_uid[UID_W-1:0];
    assign rel_head  = head_ptr[rel_idx];

    // store_ready looks only at the registered bitmap, so a slot freed by a
    // pop this cycle cannot be handed out until the following cycle
    assign store_ready = |free_map;
    assign store_fire  = store_valid & store_ready;

    assign release_valid = nonempty[rel_idx];
    assign release_data  = slot_data[rel_head];
    assign release_resp  = slot_resp[rel_head];
    assign release_last  = slot_last[rel_head];
    assign pop_fire      = release_valid & release_ready;

    // A pop that empties the list of the uid being stored to turns the store
    // into a fresh list start, so the new slot becomes both head and tail
    assign pop_single  = pop_fire && (rel_head == tail_ptr[rel_idx]);
    assign store_fresh = !nonempty[store_idx] ||
                         (pop_single && (rel_idx == store_idx));

    // Priority encoder: lowest-index free slot is the allocation target
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (free_map[i]) begin
                alloc_idx = PTR_W'(i);
            end
        end
    end

    // Slot payload and link writes; contents are meaningless while a slot is free
    always_ff @(posedge clk) begin
        if (store_fire) begin
            slot_data[alloc_idx] <= store_data;
            slot_resp[alloc_idx] <= store_resp;
            slot_last[alloc_idx] <= store_last;
            if (!store_fresh) begin
                slot_next[tail_ptr[store_idx]] <= alloc_idx;
            end
        end
    end

    // List bookkeeping: the pop updates are written first so that a store to
    // the same uid in the same cycle overrides them where the two collide
    always_ff @(posedge clk) begin
        if (rst) begin
            free_map   <= '1;
            nonempty   <= '0;
            free_count <= (PTR_W + 1)'(DEPTH);
        end else begin
            if (pop_fire) begin
                free_map[rel_head] <= 1'b1;
                if (pop_single) begin
                    nonempty[rel_idx] <= 1'b0;
                end else begin
                    head_ptr[rel_idx] <= slot_next[rel_head];
                end
            end
            if (store_fire) begin
                free_map[alloc_idx] <= 1'b0;
                tail_ptr[store_idx] <= alloc_idx;
                if (store_fresh) begin
                    head_ptr[store_idx] <= alloc_idx;
                    nonempty[store_idx] <= 1'b1;
                end
            end
            free_count <= free_count + {{PTR_W{1'b0}}, pop_fire}
                                     - {{PTR_W{1'b0}}, store_fire};
        end
    end

endmodule

// File: tb/tb_r_response_memory.sv
// tb_r_response_memory: directed stimulus with a scoreboard queue of expected
// released beats, drained by an independent monitor on every pop.
module tb_r_response_memory;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        store_valid;
    logic        store_ready;
    logic [31:0] store_uid;
    logic [63:0] store_data;
    logic [1:0]  store_resp;
    logic        store_last;
    logic [31:0] release_uid;
    logic        release_ready;
    logic        release_valid;
    logic [63:0] release_data;
    logic [1:0]  release_resp;
    logic        release_last;
    logic [5:0]  free_count;

    int    checks = 0;
    int    passes = 0;
    beat_t expq[$];

    r_response_memory dut (
        .clk           (clk),
        .rst           (rst),
        .store_valid   (store_valid),
        .store_ready   (store_ready),
        .store_uid     (store_uid),
        .store_data    (store_data),
        .store_resp    (store_resp),
        .store_last    (store_last),
        .release_uid   (release_uid),
        .release_ready (release_ready),
        .release_valid (release_valid),
        .release_data  (release_data),
        .release_resp  (release_resp),
        .release_last  (release_last),
        .free_count    (free_count)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [95:0] actual,
                               input logic [95:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic [31:0] suid,
                                 input logic [63:0] sdata, input logic [1:0] sresp,
                                 input logic slast, input logic rr,
                                 input logic [31:0] ruid);
        store_valid   = sv;
        store_uid     = suid;
        store_data    = sdata;
        store_resp    = sresp;
        store_last    = slast;
        release_ready = rr;
        release_uid   = ruid;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [63:0] d, input logic [1:0] r, input logic l);
        beat_t b;
        b.data = d;
        b.resp = r;
        b.last = l;
        expq.push_back(b);
    endtask

    // Monitor: every beat consumed by the requester must match the queue head
    always @(negedge clk) begin
        if (!rst && release_valid && release_ready) begin
            if (expq.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_pop: got data 0x%0h, expected no beat", release_data);
            end else begin
                beat_t e;
                e = expq.pop_front();
                checkOutput("release_beat", {29'd0, release_data, release_resp, release_last},
                            {29'd0, e.data, e.resp, e.last});
            end
        end
    end

    initial begin
        int anyv;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Test 1: reset and idle
        tick();
        checkOutput("ready_during_reset", store_ready, 1);
        checkOutput("valid_during_reset", release_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_ready", store_ready, 1);
        checkOutput("reset_free_count", free_count, 32);
        anyv = 0;
        for (int u = 0; u < 256; u++) begin
            release_uid = u;
            #1;
            if (release_valid !== 1'b0) anyv++;
        end
        checkOutput("reset_valid_all", anyv, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h25);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h25);
        checkOutput("ready_no_valid_free_count", free_count, 32);

        // Test 2: three beats on uid 0x25 in order
        pushExp(64'hA0, 2'd0, 1'b0);
        pushExp(64'hA1, 2'd1, 1'b0);
        pushExp(64'hA2, 2'd2, 1'b1);
        applyStimulus(1, 32'h25, 64'hA0, 2'd0, 0, 0, 32'h25); tick();
        applyStimulus(1, 32'h25, 64'hA1, 2'd1, 0, 0, 32'h25); tick();
        applyStimulus(1, 32'h25, 64'hA2, 2'd2, 1, 0, 32'h25); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h25);
        checkOutput("t2_free_after_store", free_count, 29);
        checkOutput("t2_head_data", release_data, 64'hA0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 32'h25);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h25);
        checkOutput("t2_valid_after", release_valid, 0);
        checkOutput("t2_free_after", free_count, 32);

        // Test 3: interleaved uids, upper uid bits ignored on the second 0x01
        pushExp(64'h20, 2'd0, 1'b1);
        pushExp(64'h10, 2'd0, 1'b0);
        pushExp(64'h11, 2'd3, 1'b1);
        applyStimulus(1, 32'h001, 64'h10, 2'd0, 0, 0, 0); tick();
        applyStimulus(1, 32'h002, 64'h20, 2'd0, 1, 0, 0); tick();
        applyStimulus(1, 32'h101, 64'h11, 2'd3, 1, 0, 0); tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h002); tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h001); tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h001); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h001);
        checkOutput("t3_valid_uid1", release_valid, 0);
        release_uid = 32'h002;
        #1;
        checkOutput("t3_valid_uid2", release_valid, 0);
        checkOutput("t3_free", free_count, 32);

        // Test 4: fill the pool, pop once while a store is held off
        for (int i = 0; i < 32; i++) begin
            pushExp(64'h100 + 64'(i), 2'd0, (i == 31));
            applyStimulus(1, 32'h07, 64'h100 + 64'(i), 2'd0, (i == 31), 0, 32'h07);
            tick();
        end
        pushExp(64'h200, 2'd1, 1'b1);
        applyStimulus(1, 32'h07, 64'h200, 2'd1, 1, 1, 32'h07);
        checkOutput("t4_full_ready", store_ready, 0);
        checkOutput("t4_full_count", free_count, 0);
        tick();
        applyStimulus(1, 32'h07, 64'h200, 2'd1, 1, 0, 32'h07);
        checkOutput("t4_ready_after_pop", store_ready, 1);
        checkOutput("t4_count_after_pop", free_count, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h07);
        checkOutput("t4_refull_ready", store_ready, 0);
        checkOutput("t4_refull_count", free_count, 0);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 32'h07);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h07);
        checkOutput("t4_drained_valid", release_valid, 0);
        checkOutput("t4_drained_count", free_count, 32);

        // Test 5: simultaneous pop and store on a single-beat uid
        pushExp(64'hB0, 2'd1, 1'b1);
        pushExp(64'hB1, 2'd2, 1'b1);
        applyStimulus(1, 32'h33, 64'hB0, 2'd1, 1, 0, 32'h33); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h33);
        checkOutput("t5_latency_valid", release_valid, 1);
        checkOutput("t5_first_data", release_data, 64'hB0);
        applyStimulus(1, 32'h33, 64'hB1, 2'd2, 1, 1, 32'h33); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h33);
        checkOutput("t5_valid_after_swap", release_valid, 1);
        checkOutput("t5_data_after_swap", release_data, 64'hB1);
        checkOutput("t5_count_after_swap", free_count, 31);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h33); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h33);
        checkOutput("t5_count_final", free_count, 32);

        // Test 6: reset in the middle of a store burst
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h40 + 32'(i), 64'hC0 + 64'(i), 2'd0, 0, 0, 0);
            tick();
        end
        rst = 1'b1;
        applyStimulus(1, 32'h43, 64'hC3, 2'd0, 0, 0, 0);
        tick();
        rst = 1'b0;
        applyStimulus(1, 32'h44, 64'hC4, 2'd0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        anyv = 0;
        for (int u = 32'h40; u <= 32'h44; u++) begin
            release_uid = u;
            #1;
            if (release_valid !== 1'b0) anyv++;
        end
        checkOutput("t6_valid_after_reset", anyv, 0);
        checkOutput("t6_count_after_reset", free_count, 32);
        checkOutput("t6_ready_after_reset", store_ready, 1);

        tick();
        tick();
        checkOutput("scoreboard_empty", expq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
